// File: rtl/block_mem_model.sv
// Purpose : whole-block main-memory model for a cache controller (block read / strobed block write).
// Latency : ready pulses LATENCY+WORDS+1 cycles after the request is seen in IDLE; next accept one cycle later.
// Backpr. : one transaction at a time; write wins over read in IDLE; requester holds valid until its ready pulse.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset (word array is not cleared)
//   r_valid, r_addr               read request and block address
//   r_data, r_ready               read block (word k at [k*WORD_W +: WORD_W]) and one-cycle done pulse
//   w_valid, w_addr, w_data       write request, block address and block data (same packing as r_data)
//   w_strb, w_ready               per-word write enable and one-cycle done pulse
//   busy                          high whenever a transaction is in progress
module block_mem_model #(
  parameter int    ADDR_W    = 8,
  parameter int    WORDS     = 4,
  parameter int    WORD_W    = 32,
  parameter int    LATENCY   = 16,
  parameter string INIT_FILE = ""
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     r_valid,
  input  logic [ADDR_W-1:0]        r_addr,
  output logic [WORDS*WORD_W-1:0]  r_data,
  output logic                     r_ready,
  input  logic                     w_valid,
  input  logic [ADDR_W-1:0]        w_addr,
  input  logic [WORDS*WORD_W-1:0]  w_data,
  input  logic [WORDS-1:0]         w_strb,
  output logic                     w_ready,
  output logic                     busy
);

  localparam int OFF_W     = (WORDS > 1) ? $clog2(WORDS) : 0;
  localparam int BEAT_W    = (OFF_W > 0) ? OFF_W : 1;
  localparam int CNT_W     = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
  localparam int MEM_AW    = ADDR_W + OFF_W;
  localparam int MEM_DEPTH = 1 << MEM_AW;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'((LATENCY > 0) ? LATENCY - 1 : 0);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_XFER = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic                      r_op_wr;
  logic [ADDR_W-1:0]         r_lat_addr;
  logic [WORDS*WORD_W-1:0]   r_lat_data;
  logic [WORDS-1:0]          r_lat_strb;
  logic [CNT_W-1:0]          r_cnt;
  logic [BEAT_W-1:0]         r_beat;
  logic [WORDS*WORD_W-1:0]   r_rdata;
  logic [WORD_W-1:0]         r_mem [MEM_DEPTH];

  logic [MEM_AW-1:0]         w_mem_idx;
  logic [WORD_W-1:0]         w_word;
  logic                      w_last_beat;
  logic                      w_lat_done;

  // Power-up contents of the array; rst deliberately leaves it alone.
  initial begin
    for (int i = 0; i < MEM_DEPTH; i++) r_mem[i] = '0;
  end

  // Word address = {block, beat}; with one word per block the shift is zero and beat stays 0.
  assign w_mem_idx   = (MEM_AW'(r_lat_addr) << OFF_W) | MEM_AW'(r_beat);
  assign w_word      = r_mem[w_mem_idx];
  assign w_last_beat = (r_beat == BEAT_LAST);
  assign w_lat_done  = (r_cnt == CNT_LAST);
  assign r_data      = r_rdata;

  always_comb begin
    w_next  = r_state;
    busy    = (r_state != S_IDLE);
    // Done pulses are suppressed when rst lands in the DONE cycle, so an aborted transfer never reports completion.
    r_ready = (r_state == S_DONE) && !r_op_wr && !rst;
    w_ready = (r_state == S_DONE) &&  r_op_wr && !rst;
    case (r_state)
      S_IDLE: if (w_valid || r_valid) w_next = (LATENCY == 0) ? S_XFER : S_WAIT;
      S_WAIT: if (w_lat_done) w_next = S_XFER;
      S_XFER: if (w_last_beat) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_op_wr    <= 1'b0;
      r_lat_addr <= '0;
      r_lat_data <= '0;
      r_lat_strb <= '0;
      r_cnt      <= '0;
      r_beat     <= '0;
      r_rdata    <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          r_cnt  <= '0;
          r_beat <= '0;
          // Write has priority so a writeback and its refill can be raised together.
          if (w_valid) begin
            r_op_wr    <= 1'b1;
            r_lat_addr <= w_addr;
            r_lat_data <= w_data;
            r_lat_strb <= w_strb;
          end else if (r_valid) begin
            r_op_wr    <= 1'b0;
            r_lat_addr <= r_addr;
          end
        end
        S_WAIT: r_cnt <= r_cnt + 1'b1;
        S_XFER: begin
          if (!r_op_wr) r_rdata[r_beat*WORD_W +: WORD_W] <= w_word;
          if (!w_last_beat) r_beat <= r_beat + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Array write port: one strobed word per XFER beat; beats completed before an abort stay written.
  always_ff @(posedge clk) begin
    if (!rst && (r_state == S_XFER) && r_op_wr && r_lat_strb[r_beat]) begin
      r_mem[w_mem_idx] <= r_lat_data[r_beat*WORD_W +: WORD_W];
    end
  end

endmodule
